// File: rtl/bl_zone_writer_if.sv
// Zone-writer bus: pattern controls and external zone-data read port in,
// frame strobe and backlight RAM write port out.
interface bl_zone_writer_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
) ();
  logic          en;
  logic [2:0]    mode;
  logic          dir;
  logic [DW-1:0] level_hi;
  logic [DW-1:0] level_lo;
  logic [AW-1:0] sel_idx;
  logic [DW-1:0] pix_data;
  logic          pix_rd;
  logic [AW-1:0] pix_addr;
  logic          ready;
  logic          sdbpflag;
  logic          wt_en;
  logic [AW-1:0] wt_addr;
  logic [DW-1:0] wt_data;
  logic          frame_done;

  modport slave (
    input  en, mode, dir, level_hi, level_lo, sel_idx, pix_data,
    output pix_rd, pix_addr, ready, sdbpflag, wt_en, wt_addr, wt_data, frame_done
  );

  modport master (
    output en, mode, dir, level_hi, level_lo, sel_idx, pix_data,
    input  pix_rd, pix_addr, ready, sdbpflag, wt_en, wt_addr, wt_data, frame_done
  );
endinterface

// File: rtl/bl_zone_writer.sv
// Backlight zone frame writer: config wait, per-frame sdbpflag strobe and one
// RAM word per zone from a pattern generator (EXT/FULL/CHASE/STRIPE/SINGLE).
module bl_zone_writer #(
  parameter int unsigned ZONES        = 360,
  parameter int unsigned DW           = 16,
  parameter int unsigned FRAME_PERIOD = 420000,
  parameter int unsigned CFG_WAIT     = 2500,
  parameter int unsigned FLAG_HIGH    = 29,
  parameter int unsigned WR_START     = 4,
  parameter int unsigned STEP_FRAMES  = 20,
  parameter int unsigned STRIPE       = 8
) (
  input logic             clk,
  input logic             rst_n,
  bl_zone_writer_if.slave bus
);

  localparam int unsigned AW = $clog2(ZONES);
  localparam int unsigned FW = $clog2(FRAME_PERIOD);
  localparam int unsigned CW = $clog2(CFG_WAIT + 1);
  localparam int unsigned SW = $clog2(STEP_FRAMES + 1);
  localparam int unsigned BW = $clog2(STRIPE + 1);

  localparam logic [0:0] ST_CFG = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  localparam logic [2:0] M_EXT    = 3'd0;
  localparam logic [2:0] M_FULL   = 3'd1;
  localparam logic [2:0] M_CHASE  = 3'd2;
  localparam logic [2:0] M_STRIPE = 3'd3;
  localparam logic [2:0] M_SINGLE = 3'd4;

  localparam logic [FW-1:0] F_LAST     = FW'(FRAME_PERIOD - 1);
  localparam logic [FW-1:0] F_FLAG_END = FW'(FLAG_HIGH);
  localparam logic [FW-1:0] F_RD_FIRST = FW'(WR_START);
  localparam logic [FW-1:0] F_RD_LAST  = FW'(WR_START + ZONES - 1);
  localparam logic [FW-1:0] F_WR_FIRST = FW'(WR_START + 1);
  localparam logic [FW-1:0] F_WR_LAST  = FW'(WR_START + ZONES);
  localparam logic [FW-1:0] F_DONE_PRE = FW'(WR_START + ZONES + 1);
  localparam logic [AW-1:0] Z_LAST     = AW'(ZONES - 1);
  localparam logic [CW-1:0] CFG_LAST   = CW'(CFG_WAIT - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_FRAMES - 1);
  localparam logic [BW-1:0] SUB_LAST   = BW'(STRIPE - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cfg_q, cfg_d;
  logic [FW-1:0] f_q, f_d;
  logic          act_q, act_d;
  logic [2:0]    mode_q, mode_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [AW-1:0] sel_q, sel_d;
  logic [AW-1:0] pos_q, pos_d;
  logic [SW-1:0] step_q, step_d;
  logic [BW-1:0] sub_q, sub_d;
  logic [1:0]    band_q, band_d;

  logic          ready_q, ready_d;
  logic          flag_q, flag_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;

  logic [FW-1:0] f_nxt;
  logic          act_now;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] zone_word;

  assign bus.ready      = ready_q;
  assign bus.sdbpflag   = flag_q;
  assign bus.pix_rd     = rd_q;
  assign bus.pix_addr   = raddr_q;
  assign bus.wt_en      = wen_q;
  assign bus.wt_addr    = waddr_q;
  assign bus.wt_data    = wdata_q;
  assign bus.frame_done = done_q;

  // Pattern word for the zone being written; wr_idx never exceeds ZONES-1,
  // so an out-of-range SINGLE index simply never matches.
  always_comb begin
    wr_idx    = AW'(f_q - F_WR_FIRST);
    zone_word = '0;
    case (mode_q)
      M_EXT:    zone_word = bus.pix_data;
      M_FULL:   zone_word = hi_q;
      M_CHASE:  if (wr_idx == pos_q) zone_word = hi_q;
      M_STRIPE: begin
        if (band_q == 2'd0)      zone_word = hi_q;
        else if (band_q == 2'd1) zone_word = lo_q;
      end
      M_SINGLE: if (wr_idx == sel_q) zone_word = hi_q;
      default:  zone_word = '0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    f_d     = f_q;
    act_d   = act_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sel_d   = sel_q;
    pos_d   = pos_q;
    step_d  = step_q;
    sub_d   = sub_q;
    band_d  = band_q;
    ready_d = ready_q;
    flag_d  = 1'b0;
    rd_d    = 1'b0;
    raddr_d = '0;
    wen_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    done_d  = 1'b0;
    f_nxt   = '0;
    act_now = 1'b0;

    case (state_q)
      ST_CFG: begin
        cfg_d = cfg_q + 1'b1;
        if (cfg_q == CFG_LAST) begin
          cfg_d   = cfg_q;
          ready_d = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        f_nxt   = (f_q == F_LAST) ? '0 : f_q + 1'b1;
        f_d     = f_nxt;
        act_now = act_q;

        // Frame start: sample enable, shadow the pattern controls
        if (f_q == '0) begin
          act_now = bus.en;
          act_d   = bus.en;
          sub_d   = '0;
          band_d  = 2'd0;
          if (bus.en) begin
            mode_d = bus.mode;
            dir_d  = bus.dir;
            hi_d   = bus.level_hi;
            lo_d   = bus.level_lo;
            sel_d  = bus.sel_idx;
            if (bus.mode != M_CHASE) begin
              pos_d  = '0;
              step_d = '0;
            end
          end
        end

        flag_d = act_now && (f_nxt >= FW'(1)) && (f_nxt <= F_FLAG_END);

        if (act_now && (f_nxt >= F_RD_FIRST) && (f_nxt <= F_RD_LAST)) begin
          rd_d    = 1'b1;
          raddr_d = AW'(f_nxt - F_RD_FIRST);
        end

        // Write stage: pix_data for this zone is valid in the current cycle
        if (act_q && (f_q >= F_WR_FIRST) && (f_q <= F_WR_LAST)) begin
          wen_d   = 1'b1;
          waddr_d = wr_idx;
          wdata_d = zone_word;
          if (sub_q == SUB_LAST) begin
            sub_d  = '0;
            band_d = (band_q == 2'd2) ? 2'd0 : band_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end

        if (act_q && (f_q == F_DONE_PRE)) begin
          done_d = 1'b1;
          if (mode_q == M_CHASE) begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              if (dir_q) pos_d = (pos_q == '0) ? Z_LAST : pos_q - 1'b1;
              else       pos_d = (pos_q == Z_LAST) ? '0 : pos_q + 1'b1;
            end else begin
              step_d = step_q + 1'b1;
            end
          end
        end
      end

      default: state_d = ST_CFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CFG;
      cfg_q   <= '0;
      f_q     <= '0;
      act_q   <= 1'b0;
      mode_q  <= '0;
      dir_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sel_q   <= '0;
      pos_q   <= '0;
      step_q  <= '0;
      sub_q   <= '0;
      band_q  <= 2'd0;
      ready_q <= 1'b0;
      flag_q  <= 1'b0;
      rd_q    <= 1'b0;
      raddr_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      f_q     <= f_d;
      act_q   <= act_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sel_q   <= sel_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      sub_q   <= sub_d;
      band_q  <= band_d;
      ready_q <= ready_d;
      flag_q  <= flag_d;
      rd_q    <= rd_d;
      raddr_q <= raddr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bl_zone_writer.sv
// Self-checking bench for bl_zone_writer: randomized frames compared cycle by
// cycle against a frame-level pattern/timing model.
module tb_bl_zone_writer;
  localparam int ZONES = 8;
  localparam int DW    = 16;
  localparam int FP    = 40;
  localparam int CFGW  = 10;
  localparam int FH    = 5;
  localparam int WS    = 4;
  localparam int SF    = 2;
  localparam int ST    = 2;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bl_zone_writer_if #(.AW(AW), .DW(DW)) bus ();

  bl_zone_writer #(
    .ZONES(ZONES), .DW(DW), .FRAME_PERIOD(FP), .CFG_WAIT(CFGW), .FLAG_HIGH(FH),
    .WR_START(WS), .STEP_FRAMES(SF), .STRIPE(ST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] ram   [ZONES];
  logic [15:0] exp_w [ZONES];
  int pos_m  = 0;
  int step_m = 0;

  // External zone-data source: one clock read latency, junk when not read
  always @(posedge clk) bus.pix_data <= bus.pix_rd ? ram[bus.pix_addr] : 16'($urandom);

  function automatic logic [26:0] obs();
    return {bus.ready, bus.sdbpflag, bus.pix_rd, bus.pix_addr,
            bus.wt_en, bus.wt_addr, bus.wt_data, bus.frame_done};
  endfunction

  // Expected output tuple at frame counter f, from the timing table
  function automatic logic [26:0] expect_at(int f, logic act);
    logic sdb, rd, we, dn;
    logic [2:0] ra, wa;
    logic [15:0] wd;
    sdb = act && f >= 1 && f <= FH;
    rd = 1'b0; ra = 3'd0; we = 1'b0; wa = 3'd0; wd = 16'd0;
    if (act && f >= WS && f < WS + ZONES) begin
      rd = 1'b1; ra = 3'(f - WS);
    end
    if (act && f >= WS + 2 && f < WS + 2 + ZONES) begin
      we = 1'b1; wa = 3'(f - WS - 2); wd = exp_w[f - WS - 2];
    end
    dn = act && f == WS + ZONES + 2;
    return {1'b1, sdb, rd, ra, we, wa, wd, dn};
  endfunction

  task automatic scramble();
    bus.en       = 1'($urandom);
    bus.mode     = 3'($urandom);
    bus.dir      = 1'($urandom);
    bus.level_hi = 16'($urandom);
    bus.level_lo = 16'($urandom);
    bus.sel_idx  = 3'($urandom);
  endtask

  // Runs one whole frame starting in cycle f=0; leaves the bench in the next f=0
  task automatic run_frame(input string name, input logic e, input logic [2:0] m,
                           input logic d, input logic [15:0] hi, input logic [15:0] lo,
                           input logic [2:0] sel);
    logic [26:0] got, exp;
    bus.en = e; bus.mode = m; bus.dir = d;
    bus.level_hi = hi; bus.level_lo = lo; bus.sel_idx = sel;
    if (e && m != 3'd2) begin pos_m = 0; step_m = 0; end
    for (int k = 0; k < ZONES; k++) begin
      case (m)
        3'd0:    exp_w[k] = ram[k];
        3'd1:    exp_w[k] = hi;
        3'd2:    exp_w[k] = (k == pos_m) ? hi : 16'd0;
        3'd3:    exp_w[k] = ((k / ST) % 3 == 0) ? hi : (((k / ST) % 3 == 1) ? lo : 16'd0);
        3'd4:    exp_w[k] = (int'(sel) < ZONES && k == int'(sel)) ? hi : 16'd0;
        default: exp_w[k] = 16'd0;
      endcase
    end
    for (int f = 0; f < FP; f++) begin
      if (f > 0) begin
        @(posedge clk); #1;
        scramble();
      end
      got = obs();
      exp = expect_at(f, e);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s f=%0d got=%h expected=%h", name, f, got, exp);
      end
    end
    if (e && m == 3'd2) begin
      if (step_m == SF - 1) begin
        step_m = 0;
        pos_m = d ? (pos_m + ZONES - 1) % ZONES : (pos_m + 1) % ZONES;
      end else begin
        step_m++;
      end
    end
    @(posedge clk); #1;
  endtask

  // Releases reset and checks the config wait; ends in the first f=0 cycle
  task automatic release_and_wait(input string name);
    logic [26:0] got, exp;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= CFGW; i++) begin
      @(posedge clk); #1;
      got = obs();
      exp = {(i == CFGW), 26'd0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cfg_clk=%0d got=%h expected=%h", name, i, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [26:0] got;
    rst_n = 1'b0;
    scramble();
    bus.en = 1'b1; bus.mode = 3'd1; bus.level_hi = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    got = obs();
    n_tests++;
    if (got !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%h expected=0", got);
    end
    release_and_wait("reset_cfg_wait");
  endtask

  task automatic test_full();
    run_frame("full_ffff", 1'b1, 3'd1, 1'b0, 16'hFFFF, 16'h0000, 3'd0);
    run_frame("full_ffff2", 1'b1, 3'd1, 1'b0, 16'hFFFF, 16'h1234, 3'd0);
    repeat (2) run_frame("full_rand", 1'b1, 3'd1, 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
  endtask

  task automatic test_ext();
    for (int k = 0; k < ZONES; k++) ram[k] = 16'(k * 16'h0101);
    run_frame("ext_ramp", 1'b1, 3'd0, 1'b0, 16'hFFFF, 16'h0000, 3'd0);
    repeat (2) begin
      for (int k = 0; k < ZONES; k++) ram[k] = 16'($urandom);
      run_frame("ext_rand", 1'b1, 3'd0, 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
    end
  endtask

  task automatic test_chase();
    repeat (18) run_frame("chase_up", 1'b1, 3'd2, 1'b0, 16'h0FFF, 16'($urandom), 3'($urandom));
    repeat (6) run_frame("chase_down", 1'b1, 3'd2, 1'b1, 16'h0FFF, 16'($urandom), 3'($urandom));
  endtask

  task automatic test_stripe();
    run_frame("stripe_plan", 1'b1, 3'd3, 1'b0, 16'hFFFF, 16'h0100, 3'd0);
    repeat (2) run_frame("stripe_rand", 1'b1, 3'd3, 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
  endtask

  task automatic test_single();
    run_frame("single_3", 1'b1, 3'd4, 1'b0, 16'hABCD, 16'h1111, 3'd3);
    repeat (3) run_frame("single_rand", 1'b1, 3'd4, 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
  endtask

  task automatic test_idle();
    repeat (3) run_frame("idle_pre_chase", 1'b1, 3'd2, 1'b0, 16'h0F0F, 16'h0, 3'd0);
    repeat (2) run_frame("idle_frame", 1'b0, 3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
    repeat (3) run_frame("idle_post_chase", 1'b1, 3'd2, 1'b0, 16'h0F0F, 16'h0, 3'd0);
  endtask

  task automatic test_random();
    repeat (30) begin
      for (int k = 0; k < ZONES; k++) ram[k] = 16'($urandom);
      run_frame("random_mix", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
    end
  endtask

  task automatic test_reset_abort();
    logic [26:0] got, exp;
    logic [15:0] hi;
    repeat (4) run_frame("abort_pre_chase", 1'b1, 3'd2, 1'b0, 16'h00F0, 16'h0, 3'd0);
    hi = 16'($urandom) | 16'h0001;
    bus.en = 1'b1; bus.mode = 3'd2; bus.dir = 1'b0; bus.level_hi = hi;
    for (int k = 0; k < ZONES; k++) exp_w[k] = (k == pos_m) ? hi : 16'd0;
    repeat (8) begin @(posedge clk); #1; end
    got = obs();
    exp = expect_at(8, 1'b1);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL abort_pre f=8 got=%h expected=%h", got, exp);
    end
    #2 rst_n = 1'b0;
    #1 got = obs();
    n_tests++;
    if (got !== 27'd0) begin
      n_fail++;
      $display("FAIL abort_immediate got=%h expected=0", got);
    end
    repeat (2) @(posedge clk);
    #1 got = obs();
    n_tests++;
    if (got !== 27'd0) begin
      n_fail++;
      $display("FAIL abort_held got=%h expected=0", got);
    end
    pos_m = 0; step_m = 0;
    release_and_wait("abort_cfg_wait");
    repeat (3) run_frame("abort_post_chase", 1'b1, 3'd2, 1'b0, 16'h00F0, 16'h0, 3'd0);
  endtask

  initial begin
    for (int k = 0; k < ZONES; k++) ram[k] = 16'd0;
    bus.en = 1'b0; bus.mode = 3'd0; bus.dir = 1'b0;
    bus.level_hi = 16'd0; bus.level_lo = 16'd0; bus.sel_idx = 3'd0;
    test_reset();
    test_full();
    test_ext();
    test_chase();
    test_stripe();
    test_single();
    test_idle();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
